// File: rtl/counter_seq_pkg.sv
// Shared types for the counter command sequencer: command codes, FSM states
// and count-direction encoding.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_CLEAR      = 3'd1,
    CMD_LOAD       = 3'd2,
    CMD_START_UP   = 3'd3,
    CMD_START_DOWN = 3'd4,
    CMD_STOP       = 3'd5,
    CMD_RESUME     = 3'd6,
    CMD_SET_TERM   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_seq_arb.sv
// Two-way round-robin arbiter. Grant is combinational from valid and the
// priority pointer; the pointer moves to the losing side after every accept.
module counter_seq_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (req_valid_i[ptr_q]) begin
      grant_o[ptr_q] = 1'b1;
    end else if (req_valid_i[~ptr_q]) begin
      grant_o[~ptr_q] = 1'b1;
    end
  end

  // Every grant is an accept (ready is only raised for a valid requester).
  always_comb begin
    ptr_d = ptr_q;
    if (|grant_o) begin
      ptr_d = ~grant_o[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an external up/down counter: arbitrates two command
// sources, runs the IDLE/RUN/PAUSE/DONE FSM and prescaler, and emits one-cycle
// counter strobes. Optional COUNTER_SEQ_AUTORELOAD_EN reloads at terminal count.
//
// Handshake: req_ready[i] is combinational from req_valid and the round-robin
// pointer; a command transfers on req_valid[i] && req_ready[i] at the rising
// edge. Every command is consumed in every state, even when it has no effect.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_cmd,
  input  logic [2*WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0]   ctr_value,
  output logic               ctr_inc,
  output logic               ctr_dec,
  output logic               ctr_clr,
  output logic               ctr_load,
  output logic [WIDTH-1:0]   ctr_load_val,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [1:0]       grant;
  logic             accept;
  cmd_e             cmd_sel;
  logic [WIDTH-1:0] data_sel;
  logic             tick;
  logic             at_term;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             clr_q, clr_d;
  logic             ld_q, ld_d;
  logic [WIDTH-1:0] ld_val_q, ld_val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reload_hit;

  counter_seq_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .grant_o     (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign cmd_sel   = grant[1] ? cmd_e'(req_cmd[5:3]) : cmd_e'(req_cmd[2:0]);
  assign data_sel  = grant[1] ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign at_term   = (ctr_value == term_q);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    term_d     = term_q;
    load_d     = load_q;
    ld_val_d   = ld_val_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    clr_d      = 1'b0;
    ld_d       = 1'b0;
    reload_hit = 1'b0;
    presc_d    = ((state_q == ST_RUN) && !tick) ? presc_q + 1'b1 : '0;

    // An accepted command always takes precedence; a coincident tick is dropped.
    if (accept) begin
      case (cmd_sel)
        CMD_CLEAR: begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end
        CMD_LOAD: begin
          load_d   = data_sel;
          ld_d     = 1'b1;
          ld_val_d = data_sel;
          state_d  = ST_IDLE;
        end
        CMD_START_UP, CMD_START_DOWN: begin
          dir_d   = (cmd_sel == CMD_START_DOWN) ? DIR_DOWN : DIR_UP;
          presc_d = '0;
          state_d = ST_RUN;
        end
        CMD_STOP: begin
          if (state_q == ST_RUN) state_d = ST_PAUSE;
        end
        CMD_RESUME: begin
          if (state_q == ST_PAUSE) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        CMD_SET_TERM: term_d = data_sel;
        default: ;
      endcase
    end else if (tick) begin
      if (at_term) begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        ld_d       = 1'b1;
        ld_val_d   = load_q;
        reload_hit = 1'b1;
`else
        state_d = ST_DONE;
`endif
      end else if (dir_q == DIR_DOWN) begin
        dec_d = 1'b1;
      end else begin
        inc_d = 1'b1;
      end
    end

    if (state_d != ST_RUN) presc_d = '0;
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE) || reload_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      dir_q    <= DIR_UP;
      term_q   <= '1;
      load_q   <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      clr_q    <= 1'b0;
      ld_q     <= 1'b0;
      ld_val_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
      term_q   <= term_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      clr_q    <= clr_d;
      ld_q     <= ld_d;
      ld_val_q <= ld_val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ctr_inc      = inc_q;
  assign ctr_dec      = dec_q;
  assign ctr_clr      = clr_q;
  assign ctr_load     = ld_q;
  assign ctr_load_val = ld_val_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule
